// File: rtl/request_encoder_32.sv
// request_encoder_32: registered 32-to-5 request encoder with valid/ready presentation
// Ports:
//   clock      - system clock, all state on rising edge
//   resetN     - asynchronous active-low reset
//   enable     - sample reqIn this edge when high
//   reqIn      - request lines, each high bit sets its pending flag
//   clearAll   - synchronous flush of pending requests and presentation
//   encReady   - consumer accepts encOut this cycle
//   encValid   - encOut/encMulti hold a valid index
//   encOut     - index of the selected pending request
//   encMulti   - another request was pending when encOut was loaded
//   pendingOut - current pending register
module request_encoder_32 #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        enable,
  input  logic [31:0] reqIn,
  input  logic        clearAll,
  input  logic        encReady,
  output logic        encValid,
  output logic [4:0]  encOut,
  output logic        encMulti,
  output logic [31:0] pendingOut
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  enc_q, enc_d, rr_q, rr_d;
  logic        multi_q, multi_d;
  logic [4:0]  base, low, sel;
  logic [31:0] rot;
  logic        handshake;
  // Rotate pending so the scan start sits at bit 0; lowest set bit of the
  // rotated word plus the start offset gives the wrapped round-robin winner.
  always_comb begin
    base = (PRIORITY_MODE != 0) ? rr_q : 5'd0;
    rot  = (pending_q >> base) | (pending_q << (6'd32 - {1'b0, base}));
    low  = 5'd0;
    for (int i = 31; i >= 0; i--) if (rot[i]) low = 5'(i);
    sel  = low + base;
  end
  always_comb begin
    handshake = (state_q == PRESENT) && encReady && !clearAll;
    // A bit set and retired in the same cycle stays pending (OR after mask).
    pending_d = clearAll ? '0 :
                (pending_q & ~(handshake ? (32'd1 << enc_q) : 32'd0)) | (enable ? reqIn : 32'd0);
    state_d   = state_q;
    enc_d     = enc_q;
    multi_d   = multi_q;
    rr_d      = handshake ? enc_q + 5'd1 : rr_q;
    if (state_q == IDLE) begin
      if (!clearAll && |pending_q) begin
        state_d = PRESENT;
        enc_d   = sel;
        multi_d = |(pending_q & (pending_q - 32'd1));
      end
    end else if (clearAll || encReady) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enc_q     <= '0;
      multi_q   <= 1'b0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enc_q     <= enc_d;
      multi_q   <= multi_d;
      rr_q      <= rr_d;
    end
  end
  assign encValid   = (state_q == PRESENT);
  assign encOut     = enc_q;
  assign encMulti   = multi_q;
  assign pendingOut = pending_q;
endmodule

// File: tb/tb_request_encoder_32.sv
// tb_request_encoder_32: directed self-checking bench for both priority modes
module tb_request_encoder_32;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] reqIn = '0;
  logic        clearAll = 1'b0;
  logic        encReady = 1'b0;
  logic        f_valid, f_multi, r_valid, r_multi;
  logic [4:0]  f_out, r_out;
  logic [31:0] f_pend, r_pend;
  int          n_checks = 0;
  int          n_fail = 0;

  request_encoder_32 #(.PRIORITY_MODE(0)) u_fix (
    .clock(clock), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .clearAll(clearAll), .encReady(encReady), .encValid(f_valid),
    .encOut(f_out), .encMulti(f_multi), .pendingOut(f_pend)
  );
  request_encoder_32 #(.PRIORITY_MODE(1)) u_rr (
    .clock(clock), .resetN(resetN), .enable(enable), .reqIn(reqIn),
    .clearAll(clearAll), .encReady(encReady), .encValid(r_valid),
    .encOut(r_out), .encMulti(r_multi), .pendingOut(r_pend)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    check("rst_valid", 32'(f_valid), 32'd0);
    check("rst_out", 32'(f_out), 32'd0);
    check("rst_multi", 32'(f_multi), 32'd0);
    check("rst_pend", f_pend, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    tick();
    // 1: single request, latency and retire
    enable = 1'b1; reqIn = 32'h0000_0001;
    tick();
    reqIn = '0;
    check("t1_pend", f_pend, 32'h1);
    check("t1_valid0", 32'(f_valid), 32'd0);
    tick();
    check("t1_valid", 32'(f_valid), 32'd1);
    check("t1_out", 32'(f_out), 32'd0);
    check("t1_multi", 32'(f_multi), 32'd0);
    encReady = 1'b1;
    tick();
    check("t1_pend_ret", f_pend, 32'h0);
    check("t1_valid_ret", 32'(f_valid), 32'd0);
    // 2: fixed priority sequence 0,4,31
    reqIn = 32'h8000_0011;
    tick();
    reqIn = '0;
    tick();
    check("t2_v0", 32'(f_valid), 32'd1);
    check("t2_o0", 32'(f_out), 32'd0);
    check("t2_m0", 32'(f_multi), 32'd1);
    tick();
    check("t2_idle0", 32'(f_valid), 32'd0);
    check("t2_pend0", f_pend, 32'h8000_0010);
    tick();
    check("t2_o1", 32'(f_out), 32'd4);
    check("t2_m1", 32'(f_multi), 32'd1);
    tick();
    tick();
    check("t2_v2", 32'(f_valid), 32'd1);
    check("t2_o2", 32'(f_out), 32'd31);
    check("t2_m2", 32'(f_multi), 32'd0);
    tick();
    tick();
    check("t2_end_valid", 32'(f_valid), 32'd0);
    check("t2_end_pend", f_pend, 32'd0);
    // 3: backpressure while a lower index arrives
    encReady = 1'b0; reqIn = 32'h10;
    tick();
    reqIn = '0;
    tick();
    check("t3_o", 32'(f_out), 32'd4);
    reqIn = 32'h4;
    for (int i = 0; i < 5; i++) begin
      tick();
      reqIn = '0;
      check("t3_hold_v", 32'(f_valid), 32'd1);
      check("t3_hold_o", 32'(f_out), 32'd4);
    end
    check("t3_hold_m", 32'(f_multi), 32'd0);
    check("t3_pend", f_pend, 32'h14);
    encReady = 1'b1;
    tick();
    check("t3_pend_ret", f_pend, 32'h4);
    tick();
    check("t3_next_v", 32'(f_valid), 32'd1);
    check("t3_next_o", 32'(f_out), 32'd2);
    tick();
    // 4: enable low ignores requests
    enable = 1'b0; reqIn = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_pend", f_pend, 32'd0);
      check("t4_valid", 32'(f_valid), 32'd0);
    end
    // 5: round robin with every bit continuously re-asserted
    @(negedge clock);
    resetN = 1'b0;
    #1;
    resetN = 1'b1;
    enable = 1'b1; reqIn = 32'hFFFF_FFFF; encReady = 1'b1;
    tick();
    check("t5_pend", r_pend, 32'hFFFF_FFFF);
    tick();
    check("t5_v0", 32'(r_valid), 32'd1);
    check("t5_o0", 32'(r_out), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      tick();
      check("t5_rr_o", 32'(r_out), 32'(i % 32));
      check("t5_rr_v", 32'(r_valid), 32'd1);
      check("t5_fix_o", 32'(f_out), 32'd0);
    end
    check("t5_rr_m", 32'(r_multi), 32'd1);
    // 6: async reset mid-presentation, then clear beats request
    reqIn = 32'h20; encReady = 1'b0;
    tick();
    tick();
    tick();
    check("t6_pre_v", 32'(f_valid), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check("t6_rst_v", 32'(f_valid), 32'd0);
    check("t6_rst_o", 32'(f_out), 32'd0);
    check("t6_rst_m", 32'(f_multi), 32'd0);
    check("t6_rst_p", f_pend, 32'd0);
    check("t6_rst_rv", 32'(r_valid), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    clearAll = 1'b1; reqIn = 32'h100;
    tick();
    check("t6_clr_p", f_pend, 32'd0);
    check("t6_clr_v", 32'(f_valid), 32'd0);
    clearAll = 1'b0; reqIn = 32'h8;
    tick();
    reqIn = '0;
    tick();
    check("t6_pres_o", 32'(f_out), 32'd3);
    clearAll = 1'b1; encReady = 1'b1;
    tick();
    clearAll = 1'b0;
    check("t6_flush_v", 32'(f_valid), 32'd0);
    check("t6_flush_p", f_pend, 32'd0);
    tick();
    check("t6_after_v", 32'(f_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
